// File: rtl/pcmcia_io_spi.sv
`timescale 1ns/1ps
// pcmcia_io_spi: PCMCIA I/O-space register block driving a mode-0, MSB-first SPI master.
// Latency: reads are combinational; a host write takes effect SYNC_STAGES+1 clk_52 edges after IOWR falls;
//          a byte transfer keeps BUSY high for 16*(DIV+1) cycles. Backpressure: none; a DATA write while BUSY
//          is dropped and flagged in OVR.
//
// Ports: clk_52/RESET (async, active high); host side D_in, D_out, A, IOWR, IORD, CE1, CONFIGURED, DDIR;
//        SPI side SS, SCLK, MOSI, MISO; INT (device interrupt in), IREQ_N (card interrupt out).
// Optional feature macro: SPI_IRQ_EN -- makes CTRL.IE writable and drives IREQ_N from IE & (DONE | INT_ACTIVE).
//   Without it, IE reads 0 and IREQ_N is tied high.
module pcmcia_io_spi #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_52,
  input  logic       RESET,
  input  logic [7:0] D_in,
  output logic [7:0] D_out,
  input  logic [3:0] A,
  input  logic       IOWR,
  input  logic       IORD,
  input  logic       CE1,
  input  logic       CONFIGURED,
  output logic       DDIR,
  output logic       SS,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO,
  input  logic       INT,
  output logic       IREQ_N
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Strobe / interrupt synchronisers (reset to the inactive level, 1)
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] iowr_sync_q;
  logic [SYNC_STAGES-1:0] iord_sync_q;
  logic [SYNC_STAGES-1:0] int_sync_q;
  logic                   iowr_prev_q;
  logic                   iord_prev_q;
  logic                   rd_data_q;

  logic       iowr_s;
  logic       iord_s;
  logic       int_act;
  logic       sel;
  logic [1:0] idx;
  logic       wr_evt;
  logic       wr_ok;
  logic       rd_fall;
  logic       rd_rise;

  assign iowr_s  = iowr_sync_q[SYNC_STAGES-1];
  assign iord_s  = iord_sync_q[SYNC_STAGES-1];
  assign int_act = ~int_sync_q[SYNC_STAGES-1];

  assign sel = ~CE1 & CONFIGURED & (A[3:2] == 2'b00);
  assign idx = A[1:0];

  // One write event per strobe: the first cycle the synchronised IOWR is low.
  assign wr_evt  = iowr_prev_q & ~iowr_s;
  assign wr_ok   = wr_evt & sel;
  assign rd_fall = iord_prev_q & ~iord_s;
  assign rd_rise = ~iord_prev_q & iord_s;

  always_ff @(posedge clk_52 or posedge RESET) begin
    if (RESET) begin
      iowr_sync_q <= '1;
      iord_sync_q <= '1;
      int_sync_q  <= '1;
      iowr_prev_q <= 1'b1;
      iord_prev_q <= 1'b1;
      rd_data_q   <= 1'b0;
    end else begin
      iowr_sync_q <= {iowr_sync_q[SYNC_STAGES-2:0], IOWR};
      iord_sync_q <= {iord_sync_q[SYNC_STAGES-2:0], IORD};
      int_sync_q  <= {int_sync_q[SYNC_STAGES-2:0], INT};
      iowr_prev_q <= iowr_s;
      iord_prev_q <= iord_s;
      // The address may already have moved on by the time the synchronised
      // strobe rises, so remember at the falling edge whether this read
      // targeted DATA.
      if (rd_fall) begin
        rd_data_q <= sel & (idx == 2'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers and SPI engine
  // ---------------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shift_q, shift_d;   // TX byte; bit 7 is driven on MOSI
  logic [7:0] cap_q, cap_d;
  logic [7:0] rx_q, rx_d;
  logic       busy_q, busy_d;
  logic       ovr_q, ovr_d;
  logic       done_q, done_d;
  logic       ss_q, ss_d;
  logic [3:0] div_q, div_d;
  logic       start;
  logic       ie_rd;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    cap_d    = cap_q;
    rx_d     = rx_q;
    busy_d   = busy_q;
    ovr_d    = ovr_q;
    done_d   = done_q;
    ss_d     = ss_q;
    div_d    = div_q;
    start    = 1'b0;

    if (wr_ok) begin
      case (idx)
        2'd0: begin
          if (busy_q) begin
            ovr_d = 1'b1;
          end else begin
            start = 1'b1;
          end
        end
        2'd1: begin
          if (D_in[1]) ovr_d  = 1'b0;
          if (D_in[2]) done_d = 1'b0;
        end
        2'd2: begin
          ss_d  = D_in[0];
          div_d = D_in[7:4];
        end
        default: ;
      endcase
    end

    if (rd_rise && rd_data_q) begin
      done_d = 1'b0;
    end

    // Engine evaluated last so a completing transfer's DONE wins over a clear.
    // Half-period ends on >= so a DIV lowered mid-transfer cannot strand the counter.
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d  = D_in;
          busy_d   = 1'b1;
          bitcnt_d = 3'd0;
          cnt_d    = 4'd0;
          state_d  = ST_LOW;
        end
      end
      ST_LOW: begin
        if (cnt_q >= div_q) begin
          cnt_d   = 4'd0;
          cap_d   = {cap_q[6:0], MISO};
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_HIGH: begin
        if (cnt_q >= div_q) begin
          cnt_d = 4'd0;
          if (bitcnt_q == 3'd7) begin
            rx_d    = cap_q;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            shift_d  = {shift_q[6:0], 1'b0};
            bitcnt_d = bitcnt_q + 3'd1;
            state_d  = ST_LOW;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_52 or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      bitcnt_q <= 3'd0;
      shift_q  <= 8'h00;
      cap_q    <= 8'h00;
      rx_q     <= 8'h00;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      done_q   <= 1'b0;
      ss_q     <= 1'b1;
      div_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      cap_q    <= cap_d;
      rx_q     <= rx_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
      done_q   <= done_d;
      ss_q     <= ss_d;
      div_q    <= div_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupt enable / request
  // ---------------------------------------------------------------------------
`ifdef SPI_IRQ_EN
  logic ie_q;
  logic irq_n_q;

  always_ff @(posedge clk_52 or posedge RESET) begin
    if (RESET) begin
      ie_q    <= 1'b0;
      irq_n_q <= 1'b1;
    end else begin
      if (wr_ok && (idx == 2'd2)) begin
        ie_q <= D_in[1];
      end
      irq_n_q <= ~(ie_q & (done_q | int_act));
    end
  end

  assign ie_rd  = ie_q;
  assign IREQ_N = irq_n_q;
`else
  assign ie_rd  = 1'b0;
  assign IREQ_N = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [7:0] rd_mux;

  always_comb begin
    rd_mux = 8'h00;
    case (idx)
      2'd0:    rd_mux = rx_q;
      2'd1:    rd_mux = {4'b0000, int_act, done_q, ovr_q, busy_q};
      2'd2:    rd_mux = {div_q, 2'b00, ie_rd, ss_q};
      default: rd_mux = 8'h00;
    endcase
  end

  assign DDIR  = sel & ~IORD;
  assign D_out = DDIR ? rd_mux : 8'h00;
  assign SS    = ss_q;
  assign SCLK  = (state_q == ST_HIGH);
  assign MOSI  = shift_q[7];

endmodule

// File: tb/tb_pcmcia_io_spi.sv
`timescale 1ns/1ps
// Self-checking bench for pcmcia_io_spi: a transaction-level model (transfer position t since BUSY rise)
// predicts SCLK/MOSI/SS/DDIR/D_out each cycle; directed scenarios add literal expectations.
module tb_pcmcia_io_spi;
  localparam int SYNC = 2;
`ifdef SPI_IRQ_EN
  localparam logic [7:0] CTRL_MASK = 8'hF3;
`else
  localparam logic [7:0] CTRL_MASK = 8'hF1;
`endif

  logic       clk_52 = 1'b0;
  logic       RESET;
  logic [7:0] D_in;
  logic [7:0] D_out;
  logic [3:0] A;
  logic       IOWR, IORD, CE1, CONFIGURED;
  logic       DDIR, SS, SCLK, MOSI, MISO, INT, IREQ_N;

  pcmcia_io_spi #(.SYNC_STAGES(SYNC)) dut (
    .clk_52(clk_52), .RESET(RESET), .D_in(D_in), .D_out(D_out), .A(A),
    .IOWR(IOWR), .IORD(IORD), .CE1(CE1), .CONFIGURED(CONFIGURED), .DDIR(DDIR),
    .SS(SS), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .INT(INT), .IREQ_N(IREQ_N)
  );

  always #10 clk_52 = ~clk_52;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  bit         m_busy;
  int         m_t, m_h;
  logic [7:0] m_tx, m_rx, m_sb, m_ctrl;
  bit         m_ovr, m_done;

  // Statistics observed on the DUT pins
  int         ncyc = 0, rises, first_rise, second_rise, busy_cycles;
  logic [7:0] rec;
  logic       sclk_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_t = 0; m_h = 1; m_tx = 8'h00; m_rx = 8'h00;
    m_ctrl = 8'h01; m_ovr = 0; m_done = 0;
  endtask

  task automatic clr_stats();
    rises = 0; first_rise = 0; second_rise = 0; busy_cycles = 0; rec = 8'h00;
  endtask

  function automatic bit m_sel(input logic [3:0] a);
    return !CE1 && CONFIGURED && (a[3:2] == 2'b00);
  endfunction

  function automatic logic [7:0] m_reg(input logic [1:0] i);
    case (i)
      2'd0:    return m_rx;
      2'd1:    return {4'b0000, ~INT, m_done, m_ovr, m_busy};
      2'd2:    return m_ctrl;
      default: return 8'h00;
    endcase
  endfunction

  // Per-cycle comparison against the model
  always @(negedge clk_52) begin
    ncyc++;
    if (RESET) begin
      chk("rst_ss", SS, 1'b1);
      chk("rst_sclk", SCLK, 1'b0);
      chk("rst_mosi", MOSI, 1'b0);
      chk("rst_ireq_n", IREQ_N, 1'b1);
    end else begin
      if (m_busy && m_t == 16 * m_h) begin
        m_busy = 0; m_done = 1; m_rx = m_sb;
      end
      chk("sclk", SCLK, m_busy ? ((m_t / m_h) % 2) : 0);
      if (m_busy) chk("mosi", MOSI, m_tx[7 - m_t / (2 * m_h)]);
      chk("ss", SS, m_ctrl[0]);
`ifndef SPI_IRQ_EN
      chk("ireq_n_const", IREQ_N, 1'b1);
`endif
      if (m_busy) busy_cycles++;
      if (SCLK && !sclk_prev) begin
        if (rises == 0) first_rise = ncyc;
        else if (rises == 1) second_rise = ncyc;
        rec = {rec[6:0], MOSI};
        rises++;
      end
      // Slave shifts its next bit out after each falling SCLK.
      MISO = m_busy ? m_sb[7 - m_t / (2 * m_h)] : m_sb[7];
      if (m_busy) m_t++;
    end
    sclk_prev = SCLK;
    chk("ddir", DDIR, m_sel(A) && !IORD);
    if (!(m_sel(A) && !IORD)) chk("dout_idle", D_out, 8'h00);
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    bit s;
    @(posedge clk_52); #1;
    A = a; D_in = d; IOWR = 1'b0;
    s = m_sel(a);
    repeat (SYNC + 1) @(posedge clk_52);
    if (s) begin
      case (a[1:0])
        2'd0: if (m_busy) m_ovr = 1;
              else begin m_busy = 1; m_t = 0; m_tx = d; m_h = int'(m_ctrl[7:4]) + 1; end
        2'd1: begin if (d[1]) m_ovr = 0; if (d[2]) m_done = 0; end
        2'd2: m_ctrl = d & CTRL_MASK;
        default: ;
      endcase
    end
    repeat (8) @(posedge clk_52); #1;
    IOWR = 1'b1;
    repeat (SYNC + 2) @(posedge clk_52);
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    bit s;
    @(posedge clk_52); #1;
    A = a; IORD = 1'b0;
    s = m_sel(a);
    @(negedge clk_52); #2;
    v = D_out;
    chk("rd_ddir", DDIR, s);
    chk("rd_dout", D_out, s ? m_reg(a[1:0]) : 8'h00);
    repeat (4) @(posedge clk_52); #1;
    IORD = 1'b1;
    repeat (SYNC + 1) @(posedge clk_52);
    if (s && a[1:0] == 2'd0) m_done = 0;
    repeat (2) @(posedge clk_52);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000 && m_busy; i++) @(posedge clk_52);
    chk("idle_wait_expired", m_busy, 1'b0);
    repeat (3) @(posedge clk_52);
  endtask

  logic [7:0] v;

  initial begin
    RESET = 1'b1; IOWR = 1'b1; IORD = 1'b1; CE1 = 1'b0; CONFIGURED = 1'b1;
    A = 4'h0; D_in = 8'h00; INT = 1'b1; MISO = 1'b0;
    model_reset(); m_sb = 8'h00; clr_stats();
    repeat (3) @(posedge clk_52);
    @(posedge clk_52); #1 RESET = 1'b0;

    // Reset values
    rd(4'h0, v); chk("rst_data", v, 8'h00);
    rd(4'h1, v); chk("rst_status", v, 8'h00);
    rd(4'h2, v); chk("rst_ctrl", v, 8'h01);

    // DIV=1, SS=0; send 0xA5 while slave returns 0x3C
    wr(4'h2, 8'h10);
    m_sb = 8'h3C; clr_stats();
    wr(4'h0, 8'hA5);
    wait_idle();
    chk("mosi_on_rise", rec, 8'hA5);
    chk("sclk_rises", rises, 8);
    chk("sclk_period", second_rise - first_rise, 4);
    chk("busy_cycles", busy_cycles, 32);
    rd(4'h1, v); chk("status_done", v, 8'h04);
    rd(4'h0, v); chk("rx_byte", v, 8'h3C);
    rd(4'h1, v); chk("status_after_rx", v, 8'h00);

    // Overrun: second DATA write while busy
    m_sb = 8'h5A; clr_stats();
    wr(4'h0, 8'h81);
    wr(4'h0, 8'h66);
    wait_idle();
    chk("ovr_first_byte", rec, 8'h81);
    rd(4'h1, v); chk("status_ovr", v, 8'h06);
    wr(4'h1, 8'h02);
    rd(4'h1, v); chk("status_ovr_clr", v, 8'h04);
    rd(4'h0, v); chk("rx_byte2", v, 8'h5A);

    // Blocked accesses
    CONFIGURED = 1'b0; clr_stats();
    wr(4'h0, 8'hFF);
    repeat (40) @(posedge clk_52);
    chk("unconfigured_no_sclk", rises, 0);
    rd(4'h0, v); chk("unconfigured_read", v, 8'h00);
    CONFIGURED = 1'b1; clr_stats();
    wr(4'h4, 8'hFF);
    repeat (40) @(posedge clk_52);
    chk("a4_no_sclk", rises, 0);
    rd(4'h4, v); chk("a4_read", v, 8'h00);

    // Reset in the middle of bit 3
    m_sb = 8'hC3;
    wr(4'h0, 8'h3C);
    for (int i = 0; i < 50; i++) begin
      if (m_t >= 14 || !m_busy) break;
      @(negedge clk_52);
    end
    #2 RESET = 1'b1;
    model_reset();
    #1;
    chk("midrst_sclk", SCLK, 1'b0);
    chk("midrst_ss", SS, 1'b1);
    chk("midrst_mosi", MOSI, 1'b0);
    repeat (3) @(posedge clk_52);
    @(posedge clk_52); #1 RESET = 1'b0;
    rd(4'h1, v); chk("postrst_status", v, 8'h00);
    wr(4'h2, 8'h10);
    m_sb = 8'hA5; clr_stats();
    wr(4'h0, 8'h3C);
    wait_idle();
    chk("postrst_mosi", rec, 8'h3C);
    rd(4'h0, v); chk("postrst_rx", v, 8'hA5);

    // Interrupt enable and request
    wr(4'h2, 8'h02);
    rd(4'h2, v);
`ifdef SPI_IRQ_EN
    chk("ctrl_ie", v, 8'h02);
`else
    chk("ctrl_ie_ignored", v, 8'h00);
`endif
    m_sb = 8'h99;
    wr(4'h0, 8'h55);
    wait_idle();
    @(negedge clk_52); #2;
`ifdef SPI_IRQ_EN
    chk("irq_done", IREQ_N, 1'b0);
`else
    chk("irq_done_off", IREQ_N, 1'b1);
`endif
    wr(4'h1, 8'h04);
    @(negedge clk_52); #2;
    chk("irq_after_w1c", IREQ_N, 1'b1);
    @(posedge clk_52); #1 INT = 1'b0;
    repeat (SYNC + 1) @(posedge clk_52);
    @(negedge clk_52);
`ifdef SPI_IRQ_EN
    chk("irq_int", IREQ_N, 1'b0);
`else
    chk("irq_int_off", IREQ_N, 1'b1);
`endif
    rd(4'h1, v); chk("status_int", v, 8'h08);
    INT = 1'b1;
    repeat (SYNC + 3) @(posedge clk_52);
    @(negedge clk_52); #2;
    chk("irq_int_release", IREQ_N, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/pcmcia_io_spi.md
Name: pcmcia_io_spi

Overview:
- I/O-space register block, downstream of the card configuration logic.
- Once the card is configured, it turns PCMCIA I/O cycles (IOWR/IORD with CE1) into byte transfers on the SPI master pins SS/SCLK/MOSI/MISO, and reports the INT pin.
- Host strobes are asynchronous; they are synchronised into clk_52 and drive a mode-0 SPI shift engine.
- DDIR and D_out are merged into the top-level data mux alongside the ROM and configuration outputs.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on IOWR, IORD and INT (minimum 2).

Ports:
- clk_52  in  1  system clock, 52 MHz.
- RESET  in  1  asynchronous, active-high reset.
- D_in  in  8  host write data.
- D_out  out  8  host read data; 0 when not driving.
- A  in  4  host address, low bits.
- IOWR  in  1  I/O write strobe, active low, asynchronous.
- IORD  in  1  I/O read strobe, active low, asynchronous.
- CE1  in  1  card enable, active low.
- CONFIGURED  in  1  high once the configuration option register has enabled I/O mode.
- DDIR  out  1  high while this block drives D_out.
- SS  out  1  SPI chip select, active low.
- SCLK  out  1  SPI clock, idle low.
- MOSI  out  1  SPI data out.
- MISO  in  1  SPI data in.
- INT  in  1  SPI device interrupt, active low, asynchronous.
- IREQ_N  out  1  card interrupt request, active low.

Behaviour:
- Decode: sel = ~CE1 & CONFIGURED & (A[3:2]==0). Register index = A[1:0].
- Register map:
  - 0 DATA: write loads TX and starts a transfer; read returns RX.
  - 1 STATUS, read: bit0 BUSY, bit1 OVR, bit2 DONE, bit3 INT_ACTIVE (synchronised ~INT); bits 7:4 read 0.
  - 1 STATUS, write: bit1=1 clears OVR, bit2=1 clears DONE.
  - 2 CTRL: bit0 SS level (reset 1), bit1 IE (see feature), bits 7:4 DIV, bits 3:2 read 0.
  - 3: reads 0, writes ignored.
- Read path: combinational. DDIR = sel & ~IORD. D_out = selected register while DDIR, else 0.
- Write path:
  - IOWR passes through SYNC_STAGES flops.
  - The cycle in which the synchronised IOWR is first seen low is the write event.
  - A and D_in are sampled in that cycle; they are stable for the whole strobe, min 165 ns.
  - Exactly one event per strobe.
- Read side effect: rising edge of the synchronised IORD with index 0 clears DONE.
- Write to DATA:
  - BUSY=0: TX captured, BUSY=1 on the next clock.
  - BUSY=1: data dropped, OVR=1, transfer in progress unaffected.
- SPI engine, mode 0, MSB first. Half period H = DIV+1 clk_52 cycles.
  - IDLE: SCLK=0. On start, shift_reg=TX, MOSI=TX[7], bitcnt=0, go LOW.
  - LOW: SCLK=0 for H cycles, then go HIGH and sample MISO into bit 0 of a capture register.
  - HIGH: SCLK=1 for H cycles.
    - bitcnt<7: shift left, MOSI=next bit, bitcnt+1, go LOW.
    - bitcnt==7: RX=captured byte, BUSY=0, DONE=1, SCLK=0, go IDLE.
  - A transfer takes 16*H cycles from BUSY rise to BUSY fall.
- SS follows CTRL bit0 directly. The engine never drives SS.
- Transfer with SS=1 still clocks normally; the host is responsible for SS.
- A write to DATA and a W1C of DONE in the same strobe cannot occur (different index).
- DONE set and DONE-clearing read end in the same cycle: set wins.
- CONFIGURED falling mid-transfer: host access blocked, transfer completes.
- RESET (any time, mid-transfer included): SS=1, SCLK=0, MOSI=0, TX=RX=0, BUSY=OVR=DONE=0, DIV=0, IE=0, IREQ_N=1, state IDLE. Synchroniser flops reset to 1.

Optional Feature:
- SPI_IRQ_EN defined:
  - CTRL bit1 IE is read/write.
  - IREQ_N = ~(IE & (DONE | INT_ACTIVE)), registered, one cycle after the source changes.
- SPI_IRQ_EN undefined:
  - IE reads 0, writes ignored.
  - IREQ_N is constant 1.

Test Plan:
- Reset, then read indices 0/1/2 with CONFIGURED=1 -> 0x00, 0x00, 0x01; DDIR=1 only while IORD low.
- CTRL=0x10 (DIV=1, SS=0), DATA=0xA5, MISO drives 0x3C MSB-first on falling SCLK:
  - MOSI shows 1,0,1,0,0,1,0,1 on rising edges; SCLK period 4 cycles.
  - BUSY lasts 32 cycles.
  - STATUS=0x04, DATA reads 0x3C, and the following STATUS read returns 0x00.
- Second DATA write while BUSY -> STATUS bit1=1 and the first byte's bits are unchanged; write STATUS=0x02 -> OVR=0.
- CONFIGURED=0 or A=0x4: write DATA=0xFF -> no SCLK activity, DDIR stays 0.
- RESET asserted at bit 3 of a transfer -> SCLK=0, SS=1, BUSY=0 immediately; a new transfer after release completes normally.
- SPI_IRQ_EN defined, CTRL=0x02:
  - Transfer completes -> IREQ_N=0; W1C DONE -> IREQ_N=1.
  - INT driven low -> IREQ_N=0 within SYNC_STAGES+1 cycles.
  - Undefined build: IREQ_N stays 1 throughout.
